// File: rtl/ecp5pll_phase_ctrl_if.sv
// Phase-shift request channel for ecp5pll_phase_ctrl.
// Carries a valid/ready handshake plus channel, direction and step count.
interface ecp5pll_phase_ctrl_if #(
    parameter int STEP_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_ch;
    logic              req_dir;
    logic [STEP_W-1:0] req_count;

    modport master (
        output req_valid, req_ch, req_dir, req_count,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_ch, req_dir, req_count,
        output req_ready
    );
endinterface

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift port.
// Times phasesel/phasedir/phasestep and tracks per-channel phase counts.
module ecp5pll_phase_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 8,
    parameter int STEP_W    = 8,
    parameter int ACC_W     = 10
) (
    input  logic               clk_i,
    input  logic               reset_n,
    ecp5pll_phase_ctrl_if.slave req,
    input  logic               locked_i,
    output logic [1:0]         phasesel_o,
    output logic               phasedir_o,
    output logic               phasestep_o,
    output logic               phaseloadreg_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [4*ACC_W-1:0] phase_o
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    localparam int CNT_W = 16;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STEP_W-1:0] rem_q;
    logic [1:0]        sel_q;
    logic              dir_q;
    logic              step_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;
    logic [ACC_W-1:0]  acc_q [4];

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int k = 0; k < 4; k++) acc_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req.req_valid && ready_q) begin
                        sel_q <= req.req_ch;
                        dir_q <= req.req_dir;
                        rem_q <= req.req_count;
                        if (req.req_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            cnt_q   <= CNT_W'(SETUP_CYC - 1);
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    // Counter parks at zero until the PLL reports lock.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (locked_i) begin
                        state_q <= PULSE;
                        cnt_q   <= CNT_W'(PULSE_CYC - 1);
                        step_q  <= 1'b1;
                    end
                end
                PULSE: begin
                    // A started pulse always runs to full width.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= GAP;
                        cnt_q   <= CNT_W'(GAP_CYC - 1);
                        step_q  <= 1'b0;
                        rem_q   <= rem_q - 1'b1;
                        acc_q[sel_q] <= dir_q ? acc_q[sel_q] + ACC_W'(1)
                                              : acc_q[sel_q] - ACC_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rem_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else if (locked_i) begin
                        state_q <= PULSE;
                        cnt_q   <= CNT_W'(PULSE_CYC - 1);
                        step_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.req_ready    = ready_q;
    assign phasesel_o     = sel_q;
    assign phasedir_o     = dir_q;
    assign phasestep_o    = step_q;
    assign phaseloadreg_o = 1'b0;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

    for (genvar k = 0; k < 4; k++) begin : g_phase
        assign phase_o[k*ACC_W +: ACC_W] = acc_q[k];
    end

endmodule
